pause_sched: RTL and testbench
==============================

Name: pause_sched

Overview:
- Sequencer for the AXI-stream pause/throttle block in the vita49_pack datapath.
- Holds a small table of traffic profiles. Each profile is an on-beat count, an off-cycle count and a duration in completed on/off periods.
- Steps through the table, drives the throttle block's cmd/new_cmd/on_cycle/off_cycle, and watches its stat to count completed periods.
- Lets a test or DMA flow replay a multi-phase back-pressure pattern without software intervention.

Parameters:
NUM_ENTRIES, 8, profile table depth (power of two, 2..64)
ADDR_W, 3, log2(NUM_ENTRIES)

Ports:
AXIS_ACLK  in  1  sole clock
AXIS_ARESET  in  1  asynchronous active-high reset
tbl_wr_en  in  1  table write strobe
tbl_wr_addr  in  ADDR_W  table write index
tbl_wr_on  in  32  entry on_cycle value
tbl_wr_off  in  32  entry off_cycle value
tbl_wr_dur  in  32  entry duration in completed periods (0 = run until stopped)
last_entry  in  ADDR_W  index of final entry; sampled at start
loop_en  in  1  wrap to entry 0 after last_entry; sampled at start
ctrl_start  in  1  start pulse
ctrl_stop  in  1  stop pulse
pause_stat  in  32  throttle stat input; bit1 = pause, bit0 = enable
cmd  out  32  command word to throttle block
new_cmd  out  1  one-cycle command strobe
on_cycle  out  32  current entry on value
off_cycle  out  32  current entry off value
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on natural completion
cur_entry  out  ADDR_W  entry currently applied
sched_stat  out  32  {period_cnt[23:0], 5'b0, aborted, running, busy}

Behaviour:
- Reset (async assert): all outputs 0. FSM enters IDLE. period_cnt, aborted and the pause_d edge register all clear. Table contents are not reset.
- Table writes complete in 1 cycle and are accepted in any state. An entry's values are latched into on_cycle/off_cycle only in LOAD, so a write to the active entry takes effect on its next load.
- cmd holds its last value. new_cmd is high for exactly one cycle per command.
- FSM states: IDLE, LOAD, ARM, RUN, NEXT, STOP.
- IDLE
  - ctrl_start with ctrl_stop low → LOAD. cur_entry=0; latch last_entry and loop_en; clear aborted.
  - Simultaneous start and stop → stay in IDLE.
- LOAD (1 cycle)
  - on_cycle/off_cycle ← table[cur_entry]; cmd=2 (counter reset/disable); new_cmd=1.
  - period_cnt ← 0. → ARM.
- ARM (1 cycle)
  - cmd=1 (enable); new_cmd=1; pause_d ← 0. → RUN.
- RUN
  - running=1. pause_d ← pause_stat[1] each cycle.
  - A period completes when pause_d=1 and pause_stat[1]=0 (falling edge); period_cnt increments (saturating).
  - If duration ≠ 0 and the increment reaches duration → NEXT in the same cycle.
  - Duration 0: stay in RUN until ctrl_stop.
- NEXT (1 cycle)
  - If cur_entry < latched last_entry: cur_entry+1 → LOAD.
  - Else if loop_en: cur_entry=0 → LOAD.
  - Else → STOP (natural).
- STOP (1 cycle)
  - cmd=3 (disable); new_cmd=1 → IDLE.
  - done=1 on this cycle only if the stop is natural.
- ctrl_stop in LOAD/ARM/RUN/NEXT → STOP (abort) next cycle. Sets aborted=1; no done. Stop has priority over any same-cycle period completion.
- ctrl_start while busy is ignored.
- last_entry ≥ NUM_ENTRIES cannot occur (width-limited). last_entry=0 runs a single entry.
- Edge detection is ignored outside RUN. A pause that is high when ARM completes is not counted until it next falls after being seen high in RUN.
- Latency: start → first new_cmd is 1 cycle; start → enable cmd is 2 cycles. Period completion → next entry's reset cmd is 2 cycles (RUN → NEXT → LOAD).

Test Plan:
- Reset then idle → cmd=0, new_cmd=0, busy=0, done=0, sched_stat=0 for 10 cycles.
- Table e0={on 4, off 2, dur 2}, e1={8,3,1}; last_entry=1, loop_en=0; start with a model throttle block and TVALID/TREADY always high:
  - new_cmd sequence cmd 2,1 (e0), 2,1 (e1), 3.
  - on_cycle 4 then 8.
  - done pulses once after 3 total periods; busy falls the same cycle as done.
- Same table with loop_en=1 → cur_entry sequence 0,1,0,1…; apply ctrl_stop mid-RUN → cmd=3 next cycle, aborted=1, no done.
- Entry with dur=0 → remains in RUN for 1000 cycles with period_cnt incrementing; exits only on ctrl_stop.
- Write tbl_wr_on=16 to the active entry during RUN → on_cycle unchanged until that entry is reloaded on a loop pass, then 16.
- Assert AXIS_ARESET mid-RUN → outputs 0 immediately (async); after release start works again. Simultaneous start+stop in IDLE → no new_cmd.

Source files
------------

// File: rtl/pause_sched.sv
// Profile sequencer for the AXI-stream pause/throttle block: walks a table of
// on/off/duration profiles, issues throttle commands and counts completed periods.
module pause_sched #(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 3
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESET,
  input  logic              tbl_wr_en,
  input  logic [ADDR_W-1:0] tbl_wr_addr,
  input  logic [31:0]       tbl_wr_on,
  input  logic [31:0]       tbl_wr_off,
  input  logic [31:0]       tbl_wr_dur,
  input  logic [ADDR_W-1:0] last_entry,
  input  logic              loop_en,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic [31:0]       pause_stat,
  output logic [31:0]       cmd,
  output logic              new_cmd,
  output logic [31:0]       on_cycle,
  output logic [31:0]       off_cycle,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_entry,
  output logic [31:0]       sched_stat
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ARM  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_STOP = 3'd5;

  localparam logic [31:0] CMD_ENABLE  = 32'd1;
  localparam logic [31:0] CMD_RESET   = 32'd2;
  localparam logic [31:0] CMD_DISABLE = 32'd3;

  logic [31:0] tbl_on  [NUM_ENTRIES];
  logic [31:0] tbl_off [NUM_ENTRIES];
  logic [31:0] tbl_dur [NUM_ENTRIES];

  logic [2:0]        state, nxt;
  logic [ADDR_W-1:0] entry, entry_nxt;
  logic [ADDR_W-1:0] last_q;
  logic              loop_q;
  logic              aborted;
  logic              pause_d;
  logic [31:0]       period_cnt;
  logic [31:0]       dur_q;
  logic              running;
  logic              fall;
  logic              abort;
  logic [31:0]       cnt_inc;
  logic              unused_stat;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign unused_stat = ^{pause_stat[31:2], pause_stat[0]};

  always_ff @(posedge AXIS_ACLK) begin
    if (tbl_wr_en) begin
      tbl_on[tbl_wr_addr]  <= tbl_wr_on;
      tbl_off[tbl_wr_addr] <= tbl_wr_off;
      tbl_dur[tbl_wr_addr] <= tbl_wr_dur;
    end
  end

  assign running = (state == S_RUN);
  assign fall    = running && pause_d && !pause_stat[1];
  assign cnt_inc = sat_inc(period_cnt);
  assign abort   = ctrl_stop && (state == S_LOAD || state == S_ARM ||
                                 state == S_RUN  || state == S_NEXT);

  // Stop wins over any same-cycle period completion or entry advance.
  always_comb begin
    nxt       = state;
    entry_nxt = entry;
    case (state)
      S_IDLE: begin
        if (ctrl_start && !ctrl_stop) begin
          nxt       = S_LOAD;
          entry_nxt = '0;
        end
      end
      S_LOAD: nxt = ctrl_stop ? S_STOP : S_ARM;
      S_ARM:  nxt = ctrl_stop ? S_STOP : S_RUN;
      S_RUN: begin
        if (ctrl_stop)
          nxt = S_STOP;
        else if (fall && dur_q != 32'd0 && cnt_inc == dur_q)
          nxt = S_NEXT;
      end
      S_NEXT: begin
        if (ctrl_stop) begin
          nxt = S_STOP;
        end else if (entry < last_q) begin
          nxt       = S_LOAD;
          entry_nxt = entry + 1'b1;
        end else if (loop_q) begin
          nxt       = S_LOAD;
          entry_nxt = '0;
        end else begin
          nxt = S_STOP;
        end
      end
      S_STOP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Command outputs are registered on the edge that enters LOAD/ARM/STOP,
  // so they are visible for exactly the cycle spent in that state.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state      <= S_IDLE;
      entry      <= '0;
      last_q     <= '0;
      loop_q     <= 1'b0;
      aborted    <= 1'b0;
      pause_d    <= 1'b0;
      period_cnt <= '0;
      dur_q      <= '0;
      cmd        <= '0;
      new_cmd    <= 1'b0;
      on_cycle   <= '0;
      off_cycle  <= '0;
      done       <= 1'b0;
    end else begin
      state   <= nxt;
      entry   <= entry_nxt;
      new_cmd <= 1'b0;
      done    <= 1'b0;

      if (state == S_IDLE && nxt == S_LOAD) begin
        last_q  <= last_entry;
        loop_q  <= loop_en;
        aborted <= 1'b0;
      end
      if (abort)
        aborted <= 1'b1;

      if (nxt == S_LOAD) begin
        on_cycle  <= tbl_on[entry_nxt];
        off_cycle <= tbl_off[entry_nxt];
        dur_q     <= tbl_dur[entry_nxt];
        cmd       <= CMD_RESET;
        new_cmd   <= 1'b1;
      end else if (nxt == S_ARM) begin
        cmd     <= CMD_ENABLE;
        new_cmd <= 1'b1;
      end else if (nxt == S_STOP) begin
        cmd     <= CMD_DISABLE;
        new_cmd <= 1'b1;
        done    <= !abort;
      end

      if (state == S_LOAD)
        period_cnt <= '0;
      else if (fall && !abort)
        period_cnt <= cnt_inc;

      // A pause already high at enable must be seen high in RUN before it counts.
      if (state == S_ARM)
        pause_d <= 1'b0;
      else if (running)
        pause_d <= pause_stat[1];
    end
  end

  assign busy       = (state != S_IDLE);
  assign cur_entry  = entry;
  assign sched_stat = {period_cnt[23:0], 5'b0, aborted, running, busy};

endmodule

// File: tb/tb_pause_sched.sv
// Scoreboard bench for pause_sched with a behavioural throttle block driving pause_stat.
module tb_pause_sched;

  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tbl_wr_en = 1'b0;
  logic [ADDR_W-1:0] tbl_wr_addr = '0;
  logic [31:0]       tbl_wr_on = '0, tbl_wr_off = '0, tbl_wr_dur = '0;
  logic [ADDR_W-1:0] last_entry = '0;
  logic              loop_en = 1'b0;
  logic              ctrl_start = 1'b0, ctrl_stop = 1'b0;
  logic [31:0]       pause_stat;
  logic [31:0]       cmd, on_cycle, off_cycle, sched_stat;
  logic              new_cmd, busy, done;
  logic [ADDR_W-1:0] cur_entry;

  pause_sched #(.NUM_ENTRIES(8), .ADDR_W(ADDR_W)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_on(tbl_wr_on),
    .tbl_wr_off(tbl_wr_off), .tbl_wr_dur(tbl_wr_dur),
    .last_entry(last_entry), .loop_en(loop_en),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .pause_stat(pause_stat),
    .cmd(cmd), .new_cmd(new_cmd), .on_cycle(on_cycle), .off_cycle(off_cycle),
    .busy(busy), .done(done), .cur_entry(cur_entry), .sched_stat(sched_stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       cmd;
    logic              chk_on;
    logic [31:0]       on;
    logic [ADDR_W-1:0] ent;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0, total_cnt = 0;
  int   done_cnt = 0, nc_cnt = 0, fall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic fail(input string name);
    total_cnt++;
    $display("FAIL %s: bound expired, got timeout expected event", name);
  endtask

  task automatic push(input logic [31:0] c, input logic co, input logic [31:0] on,
                      input logic [ADDR_W-1:0] ent);
    exp_t e;
    e.cmd = c; e.chk_on = co; e.on = on; e.ent = ent;
    exp_q.push_back(e);
  endtask

  // Behavioural throttle: with TVALID/TREADY tied high, on_cycle beats then off_cycle paused cycles.
  logic        t_en, t_pz;
  logic [31:0] t_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_en <= 1'b0; t_pz <= 1'b0; t_cnt <= '0;
    end else if (new_cmd) begin
      t_en <= (cmd == 32'd1); t_pz <= 1'b0; t_cnt <= '0;
    end else if (t_en) begin
      if (!t_pz) begin
        if (t_cnt + 1 >= on_cycle) begin t_pz <= 1'b1; t_cnt <= '0; end
        else t_cnt <= t_cnt + 1;
      end else begin
        if (t_cnt + 1 >= off_cycle) begin t_pz <= 1'b0; t_cnt <= '0; end
        else t_cnt <= t_cnt + 1;
      end
    end
  end
  assign pause_stat = {30'd0, t_pz, t_en};

  // Monitor: scoreboard pops on every command strobe; also tracks done pulses and periods.
  logic p1 = 1'b0, p2 = 1'b0, r1 = 1'b0, r2 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      p1 = 1'b0; p2 = 1'b0; r1 = 1'b0; r2 = 1'b0;
    end else begin
      if (new_cmd) begin
        nc_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", cmd, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cmd_seq", cmd, e.cmd);
          if (e.chk_on) begin
            chk("arm_on_cycle", on_cycle, e.on);
            chk("arm_cur_entry", {29'd0, cur_entry}, {29'd0, e.ent});
          end
        end
      end
      if (done) done_cnt++;
      if (r1 && r2 && p2 && !p1) fall_cnt++;
      if (new_cmd && cmd == 32'd2) fall_cnt = 0;
      p2 = p1; p1 = pause_stat[1];
      r2 = r1; r1 = sched_stat[1];
    end
  end

  task automatic wr(input int a, input int on, input int off, input int dur);
    @(posedge clk); #1;
    tbl_wr_en = 1'b1; tbl_wr_addr = ADDR_W'(a);
    tbl_wr_on = on; tbl_wr_off = off; tbl_wr_dur = dur;
    @(posedge clk); #1;
    tbl_wr_en = 1'b0;
  endtask

  task automatic pulse(input logic st, input logic sp);
    @(posedge clk); #1;
    ctrl_start = st; ctrl_stop = sp;
    @(posedge clk); #1;
    ctrl_start = 1'b0; ctrl_stop = 1'b0;
  endtask

  task automatic wait_q(input int sz, input int bound, input string name);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() <= sz) break;
    end
    if (i == bound) fail(name);
  endtask

  task automatic abort_run(input string name);
    int d0;
    d0 = done_cnt;
    push(32'd3, 1'b0, 0, 0);
    @(posedge clk); #1 ctrl_stop = 1'b1;
    @(posedge clk); #1 ctrl_stop = 1'b0;
    @(negedge clk);
    chk({name, "_stop_cmd"}, {31'd0, new_cmd} + (cmd << 1), 32'd7);
    chk({name, "_aborted"}, {31'd0, sched_stat[2]}, 32'd1);
    @(negedge clk);
    chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk({name, "_no_done"}, done_cnt, d0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, n0, c500;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_cmd", cmd, 32'd0);
      chk("idle_flags", {29'd0, new_cmd, busy, done}, 32'd0);
      chk("idle_stat", sched_stat, 32'd0);
    end

    // Two-entry natural run
    wr(0, 4, 2, 2);
    wr(1, 8, 3, 1);
    last_entry = 3'd1; loop_en = 1'b0;
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 4, 0);
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 8, 1);
    push(32'd3, 1'b0, 0, 0);
    pulse(1'b1, 1'b0);
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 600) fail("nat_done_wait");
    chk("nat_period_cnt", {8'd0, sched_stat[31:8]}, 32'd1);
    chk("nat_not_aborted", {31'd0, sched_stat[2]}, 32'd0);
    @(negedge clk);
    chk("nat_busy_after_done", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("nat_done_once", done_cnt, 32'd1);
    chk("nat_sb_drained", exp_q.size(), 32'd0);

    // Looping with mid-RUN abort
    loop_en = 1'b1;
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 4, 0);
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 8, 1);
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 4, 0);
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 8, 1);
    pulse(1'b1, 1'b0);
    wait_q(0, 800, "loop_wait");
    repeat (3) @(negedge clk);
    chk("loop_running", {31'd0, sched_stat[1]}, 32'd1);
    abort_run("loop");

    // Duration 0 runs until stopped
    wr(0, 3, 2, 0);
    last_entry = 3'd0; loop_en = 1'b0;
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 3, 0);
    pulse(1'b1, 1'b0);
    chk("dur0_start_clears_aborted", {31'd0, sched_stat[2]}, 32'd0);
    wait_q(0, 20, "dur0_wait");
    repeat (500) @(negedge clk);
    c500 = int'(sched_stat[31:8]);
    repeat (500) @(negedge clk);
    chk("dur0_running", {31'd0, sched_stat[1]}, 32'd1);
    chk("dur0_period_model", {8'd0, sched_stat[31:8]}, fall_cnt);
    chk("dur0_counting", {31'd0, (int'(sched_stat[31:8]) >= c500 + 90)}, 32'd1);
    abort_run("dur0");

    // Table write to the active entry applies on its next load
    wr(0, 4, 2, 1);
    wr(1, 8, 3, 1);
    last_entry = 3'd1; loop_en = 1'b1;
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 4, 0);
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 8, 1);
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 16, 0);
    pulse(1'b1, 1'b0);
    wait_q(4, 20, "wr_wait_arm");
    wr(0, 16, 2, 1);
    @(negedge clk);
    chk("wr_on_unchanged", on_cycle, 32'd4);
    chk("wr_entry_active", {29'd0, cur_entry}, 32'd0);
    wait_q(0, 800, "wr_wait_reload");
    abort_run("wr");

    // Asynchronous reset mid-RUN
    last_entry = 3'd0; loop_en = 1'b0;
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 16, 0);
    pulse(1'b1, 1'b0);
    wait_q(0, 20, "rst_wait");
    repeat (3) @(negedge clk);
    chk("rst_pre_running", {31'd0, sched_stat[1]}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_cmd", cmd, 32'd0);
    chk("rst_on_cycle", on_cycle, 32'd0);
    chk("rst_flags", {29'd0, new_cmd, busy, done}, 32'd0);
    chk("rst_stat", sched_stat, 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    push(32'd2, 1'b0, 0, 0); push(32'd1, 1'b1, 16, 0);
    pulse(1'b1, 1'b0);
    wait_q(0, 20, "rst_restart_wait");
    abort_run("rst");

    // Simultaneous start and stop in IDLE
    n0 = nc_cnt;
    pulse(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("startstop_no_cmd", nc_cnt, n0);
    chk("startstop_idle", {31'd0, busy}, 32'd0);

    chk("sb_final_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
